fc_layer_sequencer: RTL

//  Time-multiplexed controller for the fully-connected classifier stage. It computes
//  out[r] = sum_c W[r][c]*feat[c] for r=0..OUT_LEN-1 using one MAC, reading feature and

---
 rtl/fc_pkg.sv | 30 +++
 rtl/fc_mac_unit.sv | 37 +++
 rtl/fc_layer_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and helpers for the fully-connected layer sequencer
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

  // Working width for the saturation helper; wide enough for any sane ACC_W.
  localparam int FC_SAT_W = 128;

  // Accumulator width that cannot overflow for in_len signed products.
  function automatic int fc_acc_w(input int bitwidth, input int in_len);
    return 2 * bitwidth + $clog2(in_len);
  endfunction

  // Clamp a sign-extended value to the signed range of bw bits.
  function automatic logic [FC_SAT_W-1:0] sat_to_bw(input logic [FC_SAT_W-1:0] v, input int bw);
    logic signed [FC_SAT_W-1:0] hi;
    logic signed [FC_SAT_W-1:0] lo;
    hi = $signed((FC_SAT_W'(1) << (bw - 1)) - FC_SAT_W'(1));
    lo = ~hi;
    if ($signed(v) > hi) return hi;
    if ($signed(v) < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// rtl/fc_mac_unit.sv - signed multiplier feeding a wide accumulator with clear/load/enable
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int ACC_W    = fc_acc_w(BITWIDTH, 10)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [BITWIDTH-1:0] a_i,
  input  logic [BITWIDTH-1:0] b_i,
  output logic [ACC_W-1:0]    acc_o
);

  logic signed [2*BITWIDTH-1:0] prod;
  logic [ACC_W-1:0]             prod_ext;
  logic [ACC_W-1:0]             acc_q;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = {{(ACC_W - 2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
  assign acc_o    = acc_q;

  // Accumulate; load replaces the sum so a new row never sees the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= load_i ? prod_ext : acc_q + prod_ext;
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - single-MAC FC layer controller; FC_SAT_EN selects saturating output
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int IN_LEN   = 10,
  parameter int OUT_LEN  = 10,
  parameter int ACC_W    = fc_acc_w(BITWIDTH, IN_LEN)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                feat_rd_en,
  output logic [$clog2(IN_LEN)-1:0]           feat_addr,
  input  logic [BITWIDTH-1:0]                 feat_rdata,
  output logic                                w_rd_en,
  output logic [$clog2(IN_LEN*OUT_LEN)-1:0]   w_addr,
  input  logic [BITWIDTH-1:0]                 w_rdata,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(OUT_LEN)-1:0]          out_idx,
  output logic [BITWIDTH-1:0]                 out_data
);

  localparam int FA_W = $clog2(IN_LEN);
  localparam int WA_W = $clog2(IN_LEN * OUT_LEN);
  localparam int RI_W = $clog2(OUT_LEN);
  // Column counter runs one past the last column for the drain cycle.
  localparam int CW   = $clog2(IN_LEN + 1);

  fc_state_t         state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RI_W-1:0]   row_q, row_d;
  logic [WA_W-1:0]   wbase_q, wbase_d;
  logic [ACC_W-1:0]  acc;
  logic [BITWIDTH-1:0] result;
  logic              rd_active;
  logic              last_col;
  logic              last_row;
  logic              mac_clr, mac_load, mac_en;

  assign rd_active = (state_q == MAC) && (col_q < CW'(IN_LEN));
  assign last_col  = (col_q == CW'(IN_LEN));
  assign last_row  = (row_q == RI_W'(OUT_LEN - 1));

  // Data returns one cycle after the read, so column c is summed while column c+1 is issued.
  assign mac_clr  = (state_q == IDLE) && start;
  assign mac_en   = (state_q == MAC) && (col_q != '0);
  assign mac_load = (col_q == CW'(1));

  fc_mac_unit #(
    .BITWIDTH (BITWIDTH),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .load_i (mac_load),
    .en_i   (mac_en),
    .a_i    (feat_rdata),
    .b_i    (w_rdata),
    .acc_o  (acc)
  );

  // Next-state logic for the FSM and the row/column/weight-base counters.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wbase_d = wbase_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          col_d   = '0;
          row_d   = '0;
          wbase_d = '0;
        end
      end
      MAC: begin
        if (last_col) begin
          state_d = WRITE;
          col_d   = '0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      WRITE: begin
        if (out_ready) begin
          if (last_row) begin
            state_d = DONE;
          end else begin
            state_d = MAC;
            row_d   = row_q + RI_W'(1);
            wbase_d = wbase_q + WA_W'(IN_LEN);
          end
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
        wbase_d = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wbase_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wbase_q <= wbase_d;
    end
  end

`ifdef FC_SAT_EN
  logic [FC_SAT_W-1:0] acc_sat;
  logic                unused_sat_hi;
  // Clamp the full-precision sum into the output range.
  always_comb begin
    acc_sat = sat_to_bw({{(FC_SAT_W - ACC_W){acc[ACC_W-1]}}, acc}, BITWIDTH);
  end
  assign result        = acc_sat[BITWIDTH-1:0];
  assign unused_sat_hi = ^acc_sat[FC_SAT_W-1:BITWIDTH];
`else
  logic unused_acc_hi;
  assign result        = acc[BITWIDTH-1:0];
  assign unused_acc_hi = ^acc[ACC_W-1:BITWIDTH];
`endif

  assign busy       = (state_q == MAC) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign feat_rd_en = rd_active;
  assign w_rd_en    = rd_active;
  assign feat_addr  = rd_active ? col_q[FA_W-1:0] : '0;
  assign w_addr     = rd_active ? wbase_q + WA_W'(col_q) : '0;
  assign out_valid  = (state_q == WRITE);
  assign out_idx    = out_valid ? row_q : '0;
  assign out_data   = out_valid ? result : '0;

endmodule
